chopper_sequencer: RTL
======================

# chopper_sequencer

Current-chopper phase controller for one microstepper coil bridge. It sequences the shared countdown timer through blanking and fixed off-time phases. It gates the bridge on the comparator's overcurrent signal and latches a short-circuit fault after repeated immediate trips. It sits between the step/phase logic (via `enable`) and the external countdown timer plus bridge drivers.

## Interface
- `WIDTH`, 10, width of time values and of the timer count.
- `SHORT_LIMIT`, 3, consecutive immediate trips that latch a fault (1..15).

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  coil drive request from the phase logic.
- `overcurrent`  in  1  comparator trip, already synchronized to `clk`.
- `blank_time`  in  WIDTH  blanking length; sampled when the BLANK load is issued.
- `off_time`  in  WIDTH  fixed off-time length; sampled when the OFF load is issued.
- `timer_count`  in  WIDTH  current value of the external countdown timer.
- `timer_load`  out  1  one-cycle load strobe to the timer.
- `timer_start`  out  WIDTH  load value; valid only while `timer_load`=1.
- `bridge_on`  out  1  bridge drive; high in BLANK and ON.
- `decay`  out  1  decay drive; high in OFF.
- `fault`  out  1  short-circuit fault; high in FAULT.

## Operation
- States:
  - IDLE: bridge off.
  - BLANK: bridge on, `overcurrent` ignored.
  - ON: bridge on, watching `overcurrent`.
  - OFF: fixed decay.
  - FAULT: latched, bridge off.
- IDLE to BLANK when `enable`=1.
- BLANK to ON when the timer expires.
- ON to OFF when `overcurrent`=1.
- OFF on expiry: to BLANK if `enable`=1, else to IDLE.
- BLANK or ON to IDLE when `enable`=0. This has priority over `overcurrent` and over timer expiry in the same cycle.
- OFF ignores `enable` until expiry; the decay always completes.
- FAULT to IDLE only when `enable`=0.
- Timer sequencing:
  - On entry to BLANK or OFF, `timer_load`=1 for exactly the first cycle of the state.
  - `timer_start` = `blank_time` or `off_time` respectively, captured from the inputs in that cycle.
  - In the next cycle the timer shows the loaded value.
  - Expiry is `timer_count`==0 in any cycle of the state other than its first. The stale count in the load cycle is never used.
  - ON issues no load.
- Short detection:
  - An "immediate trip" is `overcurrent`=1 in the first cycle of ON.
  - Each immediate trip increments `short_cnt` (4 bits, saturating).
  - A trip in any later ON cycle clears `short_cnt` to 0.
  - When an immediate trip brings `short_cnt` to `SHORT_LIMIT`, the next state is FAULT instead of OFF.
  - `short_cnt` clears on entering IDLE.
- Outputs are decoded from registered state and are glitch-free. `bridge_on` and `decay` are never both 1.

## Timing
- Reset (async assert) sets:
  - state=IDLE, `short_cnt`=0.
  - `timer_load`=0, `timer_start`=0.
  - `bridge_on`=0, `decay`=0, `fault`=0.
- Reset release is synchronous to `clk`.
- Reset mid-phase aborts immediately. The external timer is not touched, and its residual count is ignored because every state reloads or waits for the load cycle.
- Latency and durations:
  - `enable` rising to `bridge_on`=1: one cycle (registered).
  - BLANK length: `blank_time`+2 cycles.
  - OFF length: `off_time`+2 cycles.
  - A value of 0 gives 2 cycles.
- Minimum chop period: BLANK (≥2) + ON (≥1) + OFF (≥2) cycles.
- `overcurrent` during BLANK has no effect and is not counted.
- `timer_count` values other than 0 are never compared. Wrap-around is the timer's concern; it saturates at 0.

## Structure
- Shared package:
  - State encoding: IDLE=0, BLANK=1, ON=2, OFF=3, FAULT=4, 3 bits.
  - `SHORT_CNT_W`=4.
- No sub-module. The countdown timer stays a separate instance at the coil level and is sequenced through the load/count ports.
- A `first_cycle` flag register marks the load cycle and the first ON cycle.

## Test plan
- `blank_time`=3, `off_time`=5, `enable`=1, trip on the 4th ON cycle.
  - BLANK is 5 cycles with `timer_load` in cycle 1, `timer_start`=3.
  - OFF is 7 cycles with `timer_start`=5.
  - Then BLANK again.
- `overcurrent` held high throughout BLANK.
  - No transition; ON is entered after 5 cycles.
  - Immediate trip to OFF, `short_cnt`=1.
- Three consecutive immediate trips, `SHORT_LIMIT`=3.
  - After the third trip: `fault`=1, `bridge_on`=0, no OFF load.
  - Drop `enable` → IDLE next cycle, `fault`=0.
- `enable` falls in the same cycle as a trip in ON.
  - Next state IDLE, `decay`=0, no load.
- `enable` falls mid-OFF.
  - OFF runs its full `off_time`+2 cycles, then IDLE.
- `blank_time`=0, `off_time`=0.
  - BLANK and OFF are 2 cycles each.
- Reset asserted mid-BLANK.
  - All outputs 0 asynchronously.
  - After release with `enable`=1, a fresh BLANK load is issued.

Source files
------------

// File: rtl/chopper_sequencer_pkg.sv
// Shared definitions for the coil current-chopper phase controller.
// State encoding is fixed so the coil-level debug taps can decode it.
package chopper_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BLANK = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int SHORT_CNT_W = 4;

    function automatic logic [SHORT_CNT_W-1:0] sat_inc(input logic [SHORT_CNT_W-1:0] value);
        return (value == {SHORT_CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/chopper_sequencer.sv
// Chopper phase sequencer: drives the shared countdown timer through blanking
// and fixed off-time, gates the bridge on overcurrent, latches a short fault.
module chopper_sequencer
    import chopper_sequencer_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SHORT_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             overcurrent,
    input  logic [WIDTH-1:0] blank_time,
    input  logic [WIDTH-1:0] off_time,
    input  logic [WIDTH-1:0] timer_count,
    output logic             timer_load,
    output logic [WIDTH-1:0] timer_start,
    output logic             bridge_on,
    output logic             decay,
    output logic             fault
);

    state_t                 state_reg, state_next;
    logic                   first_cycle_reg, first_cycle_next;
    logic [SHORT_CNT_W-1:0] short_cnt_reg, short_cnt_next;
    logic [SHORT_CNT_W-1:0] short_cnt_inc;
    logic                   expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            first_cycle_reg <= 1'b0;
            short_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            first_cycle_reg <= first_cycle_next;
            short_cnt_reg   <= short_cnt_next;
        end
    end

    // The timer still holds a stale count during the load cycle, so expiry
    // is only honoured once the loaded value is visible.
    assign expired       = !first_cycle_reg && (timer_count == '0);
    assign short_cnt_inc = sat_inc(short_cnt_reg);

    always_comb begin
        state_next     = state_reg;
        short_cnt_next = short_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable)
                    state_next = ST_BLANK;
            end
            ST_BLANK: begin
                if (!enable)
                    state_next = ST_IDLE;
                else if (expired)
                    state_next = ST_ON;
            end
            ST_ON: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (overcurrent) begin
                    if (first_cycle_reg) begin
                        short_cnt_next = short_cnt_inc;
                        state_next = (short_cnt_inc == SHORT_CNT_W'(SHORT_LIMIT)) ? ST_FAULT : ST_OFF;
                    end else begin
                        short_cnt_next = '0;
                        state_next     = ST_OFF;
                    end
                end
            end
            ST_OFF: begin
                if (expired)
                    state_next = enable ? ST_BLANK : ST_IDLE;
            end
            ST_FAULT: begin
                if (!enable)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (state_next == ST_IDLE)
            short_cnt_next = '0;

        first_cycle_next = (state_next != state_reg);
    end

    // Outputs decode registered state only; timer_start is gated so it
    // reads zero outside the load strobe.
    assign bridge_on   = (state_reg == ST_BLANK) || (state_reg == ST_ON);
    assign decay       = (state_reg == ST_OFF);
    assign fault       = (state_reg == ST_FAULT);
    assign timer_load  = first_cycle_reg && ((state_reg == ST_BLANK) || (state_reg == ST_OFF));
    assign timer_start = !timer_load ? '0 :
                         (state_reg == ST_BLANK) ? blank_time : off_time;

endmodule
